// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the shared multiply/divide cores: launches the core,
// fixes divide signs, holds the {hi,lo} result with a ready flag and stalls EX meanwhile.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        ex_advance_i,
  input  logic        mult_start_i,
  input  logic        signed_mult_i,
  input  logic [31:0] mult_opdata1_i,
  input  logic [31:0] mult_opdata2_i,
  input  logic        div_start_i,
  input  logic        signed_div_i,
  input  logic [31:0] div_opdata1_i,
  input  logic [31:0] div_opdata2_i,
  output logic [31:0] mul_core_a_o,
  output logic [31:0] mul_core_b_o,
  output logic        mul_core_sgn_o,
  input  logic [63:0] mul_core_res_i,
  output logic        div_core_start_o,
  output logic        div_core_cancel_o,
  output logic [31:0] div_core_n_o,
  output logic [31:0] div_core_d_o,
  input  logic        div_core_done_i,
  input  logic [31:0] div_core_q_i,
  input  logic [31:0] div_core_r_i,
  output logic [63:0] mult_result_o,
  output logic        mult_ready_o,
  output logic [63:0] div_result_o,
  output logic        div_ready_o,
  output logic        stallreq_o,
  output logic [1:0]  state_o
);

  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_DIV_BUSY = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_is_div_q, op_is_div_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               mul_sgn_q, mul_sgn_d;
  logic               div_start_q, div_start_d;
  logic               div_cancel_q, div_cancel_d;
  logic [31:0]        div_n_q, div_n_d;
  logic [31:0]        div_d_q, div_d_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [63:0]        mult_res_q, mult_res_d;
  logic [63:0]        div_res_q, div_res_d;

  logic [31:0]        dividend_abs;
  logic [31:0]        divisor_abs;
  logic [31:0]        quot_fix;
  logic [31:0]        rem_fix;

  // Magnitudes for the unsigned core; 32'h80000000 maps to itself, which
  // makes MIN/-1 come out as quotient 32'h80000000, remainder 0.
  always_comb begin
    dividend_abs = (signed_div_i && div_opdata1_i[31]) ? (~div_opdata1_i + 32'd1) : div_opdata1_i;
    divisor_abs  = (signed_div_i && div_opdata2_i[31]) ? (~div_opdata2_i + 32'd1) : div_opdata2_i;
    quot_fix     = q_neg_q ? (~div_core_q_i + 32'd1) : div_core_q_i;
    rem_fix      = r_neg_q ? (~div_core_r_i + 32'd1) : div_core_r_i;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_is_div_d  = op_is_div_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_sgn_d    = mul_sgn_q;
    div_start_d  = 1'b0;
    div_cancel_d = 1'b0;
    div_n_d      = div_n_q;
    div_d_d      = div_d_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    mult_res_d   = mult_res_q;
    div_res_d    = div_res_q;

    unique case (state_q)
      S_IDLE: begin
        if (!flush_i) begin
          if (div_start_i) begin
            op_is_div_d = 1'b1;
            q_neg_d     = signed_div_i & (div_opdata1_i[31] ^ div_opdata2_i[31]);
            r_neg_d     = signed_div_i & div_opdata1_i[31];
            div_n_d     = dividend_abs;
            div_d_d     = divisor_abs;
            if (div_opdata2_i == 32'd0) begin
              div_res_d = 64'd0;
              state_d   = S_DONE;
            end else begin
              div_start_d = 1'b1;
              state_d     = S_DIV_BUSY;
            end
          end else if (mult_start_i) begin
            op_is_div_d = 1'b0;
            mul_a_d     = mult_opdata1_i;
            mul_b_d     = mult_opdata2_i;
            mul_sgn_d   = signed_mult_i;
            cnt_d       = CNT_W'(MUL_LAT);
            state_d     = S_MUL_BUSY;
          end
        end
      end
      S_MUL_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (flush_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          mult_res_d = mul_core_res_i;
          state_d    = S_DONE;
        end
      end
      S_DIV_BUSY: begin
        // Flush wins over a same-cycle done pulse.
        if (flush_i) begin
          div_cancel_d = 1'b1;
          state_d      = S_IDLE;
        end else if (div_core_done_i) begin
          div_res_d = {rem_fix, quot_fix};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (ex_advance_i || flush_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_is_div_q  <= 1'b0;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      mul_sgn_q    <= 1'b0;
      div_start_q  <= 1'b0;
      div_cancel_q <= 1'b0;
      div_n_q      <= 32'd0;
      div_d_q      <= 32'd0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      mult_res_q   <= 64'd0;
      div_res_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_is_div_q  <= op_is_div_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_sgn_q    <= mul_sgn_d;
      div_start_q  <= div_start_d;
      div_cancel_q <= div_cancel_d;
      div_n_q      <= div_n_d;
      div_d_q      <= div_d_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      mult_res_q   <= mult_res_d;
      div_res_q    <= div_res_d;
    end
  end

  // Ready/result handshake: a ready flag qualifies its held result for as
  // long as the FSM sits in DONE; EX consumes it by raising ex_advance_i.
  always_comb begin
    mul_core_a_o      = mul_a_q;
    mul_core_b_o      = mul_b_q;
    mul_core_sgn_o    = mul_sgn_q;
    div_core_start_o  = div_start_q;
    div_core_cancel_o = div_cancel_q;
    div_core_n_o      = div_n_q;
    div_core_d_o      = div_d_q;
    mult_result_o     = mult_res_q;
    div_result_o      = div_res_q;
    mult_ready_o      = (state_q == S_DONE) & ~op_is_div_q;
    div_ready_o       = (state_q == S_DONE) & op_is_div_q;
    stallreq_o        = rst & (mult_start_i | div_start_i) & (state_q != S_DONE) & ~flush_i;
    state_o           = state_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: behavioural mult/div cores, expected-result
// queue filled at issue time, and a monitor that checks each ready result.
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, ex_advance_i;
  logic        mult_start_i, signed_mult_i;
  logic [31:0] mult_opdata1_i, mult_opdata2_i;
  logic        div_start_i, signed_div_i;
  logic [31:0] div_opdata1_i, div_opdata2_i;
  logic [31:0] mul_core_a_o, mul_core_b_o;
  logic        mul_core_sgn_o;
  logic [63:0] mul_core_res_i;
  logic        div_core_start_o, div_core_cancel_o;
  logic [31:0] div_core_n_o, div_core_d_o;
  logic        div_core_done_i;
  logic [31:0] div_core_q_i, div_core_r_i;
  logic [63:0] mult_result_o, div_result_o;
  logic        mult_ready_o, div_ready_o, stallreq_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  int start_cnt = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .ex_advance_i(ex_advance_i),
    .mult_start_i(mult_start_i), .signed_mult_i(signed_mult_i),
    .mult_opdata1_i(mult_opdata1_i), .mult_opdata2_i(mult_opdata2_i),
    .div_start_i(div_start_i), .signed_div_i(signed_div_i),
    .div_opdata1_i(div_opdata1_i), .div_opdata2_i(div_opdata2_i),
    .mul_core_a_o(mul_core_a_o), .mul_core_b_o(mul_core_b_o),
    .mul_core_sgn_o(mul_core_sgn_o), .mul_core_res_i(mul_core_res_i),
    .div_core_start_o(div_core_start_o), .div_core_cancel_o(div_core_cancel_o),
    .div_core_n_o(div_core_n_o), .div_core_d_o(div_core_d_o),
    .div_core_done_i(div_core_done_i), .div_core_q_i(div_core_q_i),
    .div_core_r_i(div_core_r_i), .mult_result_o(mult_result_o),
    .mult_ready_o(mult_ready_o), .div_result_o(div_result_o),
    .div_ready_o(div_ready_o), .stallreq_o(stallreq_o), .state_o(state_o)
  );

  // Multiplier core: one register stage behind the held operands.
  always @(posedge clk) begin
    if (mul_core_sgn_o)
      mul_core_res_i <= $signed({{32{mul_core_a_o[31]}}, mul_core_a_o}) *
                        $signed({{32{mul_core_b_o[31]}}, mul_core_b_o});
    else
      mul_core_res_i <= {32'd0, mul_core_a_o} * {32'd0, mul_core_b_o};
  end

  // Divider core with adjustable latency, plus an injection path for stray done pulses.
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  int          core_cnt = 0;
  int          div_lat = 3;
  logic [31:0] core_n, core_d, core_q, core_r;
  logic        inj_done;
  logic [31:0] inj_q, inj_r;

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (div_core_cancel_o) begin
      core_busy <= 1'b0;
    end else if (div_core_start_o) begin
      core_busy <= 1'b1;
      core_cnt  <= div_lat;
      core_n    <= div_core_n_o;
      core_d    <= div_core_d_o;
    end else if (core_busy) begin
      if (core_cnt <= 1) begin
        core_busy <= 1'b0;
        core_done <= 1'b1;
        core_q    <= core_n / core_d;
        core_r    <= core_n % core_d;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  assign div_core_done_i = core_done | inj_done;
  assign div_core_q_i    = inj_done ? inj_q : core_q;
  assign div_core_r_i    = inj_done ? inj_r : core_r;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [263:0] v;
    v = {mul_core_a_o, mul_core_b_o, mul_core_sgn_o, div_core_start_o, div_core_cancel_o,
         div_core_n_o, div_core_d_o, mult_result_o, mult_ready_o, div_result_o,
         div_ready_o, stallreq_o, state_o};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs %h, expected all zero", name, v);
    end
  endtask

  // Monitor: pops one expectation per ready assertion, then checks it holds.
  logic        prev_rdy = 1'b0;
  logic [64:0] held_res;
  always @(negedge clk) begin
    logic        rdy;
    logic [64:0] act;
    if (div_core_start_o) start_cnt++;
    if (!rst) begin
      prev_rdy = 1'b0;
    end else begin
      rdy = mult_ready_o | div_ready_o;
      act = {div_ready_o, div_ready_o ? div_result_o : mult_result_o};
      if (rdy && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h, expected no result", act);
        end else begin
          check("result", act, exp_q.pop_front());
        end
        held_res = act;
      end else if (rdy) begin
        check("result_hold", act, held_res);
      end
      prev_rdy = rdy;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mult_start_i = 1'b0;
    div_start_i  = 1'b0;
    ex_advance_i = 1'b0;
    flush_i      = 1'b0;
  endtask

  // Waits for ready (bounded), consumes it with ex_advance_i, returns in IDLE.
  task automatic wait_done();
    int n = 0;
    smp();
    while (!(mult_ready_o | div_ready_o) && n < 60) begin
      smp();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: ready 0 after 60 cycles, expected 1");
    end
    ex_advance_i = 1'b1;
    cyc();
    clear_inputs();
  endtask

  task automatic issue_mult(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_res);
    exp_q.push_back({1'b0, exp_res});
    mult_start_i   = 1'b1;
    signed_mult_i  = sgn;
    mult_opdata1_i = a;
    mult_opdata2_i = b;
    wait_done();
  endtask

  task automatic issue_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_n, input logic [31:0] exp_d,
                           input logic [63:0] exp_res);
    exp_q.push_back({1'b1, exp_res});
    div_start_i   = 1'b1;
    signed_div_i  = sgn;
    div_opdata1_i = a;
    div_opdata2_i = b;
    cyc();
    smp();
    check("div_start_pulse", 65'(div_core_start_o), 65'(1));
    check("div_core_n", 65'(div_core_n_o), 65'(exp_n));
    check("div_core_d", 65'(div_core_d_o), 65'(exp_d));
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    rst = 1'b0;
    clear_inputs();
    signed_mult_i  = 1'b0;
    mult_opdata1_i = 32'd0;
    mult_opdata2_i = 32'd0;
    signed_div_i   = 1'b0;
    div_opdata1_i  = 32'd0;
    div_opdata2_i  = 32'd0;
    inj_done = 1'b0;
    inj_q    = 32'd0;
    inj_r    = 32'd0;
    #12;
    chk_zero("reset_outputs");
    smp();
    rst = 1'b1;
    cyc();

    // 3*5 unsigned: stall for three cycles, ready three cycles after start.
    exp_q.push_back({1'b0, 64'hF});
    mult_start_i = 1'b1; signed_mult_i = 1'b0; mult_opdata1_i = 32'd3; mult_opdata2_i = 32'd5;
    smp();
    check("stall_t0", 65'(stallreq_o), 65'(1));
    check("mready_t0", 65'(mult_ready_o), 65'(0));
    cyc(); smp();
    check("stall_t1", 65'(stallreq_o), 65'(1));
    check("mul_core_a", 65'(mul_core_a_o), 65'(3));
    check("mul_core_b", 65'(mul_core_b_o), 65'(5));
    check("state_mul_busy", 65'(state_o), 65'(1));
    cyc(); smp();
    check("stall_t2", 65'(stallreq_o), 65'(1));
    check("mready_t2", 65'(mult_ready_o), 65'(0));
    cyc();
    ex_advance_i = 1'b1;
    smp();
    check("mready_t3", 65'(mult_ready_o), 65'(1));
    check("stall_t3", 65'(stallreq_o), 65'(0));
    cyc();
    clear_inputs();
    smp();
    check("mready_cleared", 65'(mult_ready_o), 65'(0));
    check("state_idle_after_adv", 65'(state_o), 65'(0));
    cyc();

    issue_mult(1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    issue_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);

    issue_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    issue_div(1'b0, 32'd100, 32'd7, 32'd100, 32'd7, {32'd2, 32'd14});
    issue_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd2, {32'd1, 32'hFFFFFFFD});
    issue_div(1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC});
    issue_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1, {32'd0, 32'h80000000});

    // Both starts high: divide wins.
    mult_start_i = 1'b1; mult_opdata1_i = 32'd4; mult_opdata2_i = 32'd4;
    issue_div(1'b0, 32'd20, 32'd3, 32'd20, 32'd3, {32'd2, 32'd6});

    // Divide by zero: no core launch, ready next cycle, zero result.
    sc = start_cnt;
    exp_q.push_back({1'b1, 64'd0});
    div_start_i = 1'b1; signed_div_i = 1'b0; div_opdata1_i = 32'd100; div_opdata2_i = 32'd0;
    smp();
    check("div0_stall", 65'(stallreq_o), 65'(1));
    cyc(); smp();
    check("div0_ready", 65'(div_ready_o), 65'(1));
    ex_advance_i = 1'b1;
    cyc();
    clear_inputs();
    smp();
    check("div0_no_launch", 65'(start_cnt - sc), 65'(0));
    cyc();

    // Flush in the 3rd DIV_BUSY cycle with a same-cycle done, then a late done.
    div_lat = 8;
    div_start_i = 1'b1; signed_div_i = 1'b0; div_opdata1_i = 32'd50; div_opdata2_i = 32'd5;
    cyc(); cyc(); cyc();
    flush_i = 1'b1; div_start_i = 1'b0; inj_done = 1'b1; inj_q = 32'd10; inj_r = 32'd0;
    smp();
    check("flush_no_stall", 65'(stallreq_o), 65'(0));
    cyc();
    flush_i = 1'b0; inj_done = 1'b0;
    smp();
    check("cancel_pulse", 65'(div_core_cancel_o), 65'(1));
    check("flush_to_idle", 65'(state_o), 65'(0));
    cyc(); smp();
    check("cancel_one_cycle", 65'(div_core_cancel_o), 65'(0));
    cyc();
    inj_done = 1'b1;
    smp();
    check("late_done_ignored", 65'(div_ready_o), 65'(0));
    cyc();
    inj_done = 1'b0;
    smp();
    check("late_done_state", 65'(state_o), 65'(0));
    check("late_done_ready", 65'(div_ready_o), 65'(0));
    div_lat = 3;
    cyc();

    // Flush during MUL_BUSY: no result.
    mult_start_i = 1'b1; signed_mult_i = 1'b0; mult_opdata1_i = 32'd9; mult_opdata2_i = 32'd9;
    cyc();
    flush_i = 1'b1; mult_start_i = 1'b0;
    cyc();
    flush_i = 1'b0;
    smp();
    check("mflush_idle", 65'(state_o), 65'(0));
    cyc(); smp();
    check("mflush_no_ready_a", 65'(mult_ready_o), 65'(0));
    cyc(); smp();
    check("mflush_no_ready_b", 65'(mult_ready_o), 65'(0));
    cyc();

    // Start with flush in IDLE: no stall, no launch.
    mult_start_i = 1'b1; flush_i = 1'b1;
    smp();
    check("idle_flush_stall", 65'(stallreq_o), 65'(0));
    cyc();
    clear_inputs();
    smp();
    check("idle_flush_state", 65'(state_o), 65'(0));
    cyc();

    // DONE held for 4 cycles with start still asserted and operands changing.
    exp_q.push_back({1'b0, 64'hFFFFFFFE_00000001});
    mult_start_i = 1'b1; signed_mult_i = 1'b0;
    mult_opdata1_i = 32'hFFFFFFFF; mult_opdata2_i = 32'hFFFFFFFF;
    cyc(); cyc(); cyc();
    mult_opdata1_i = 32'd1; signed_mult_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      check("done_hold_state", 65'(state_o), 65'(3));
      check("done_no_relaunch", 65'(mul_core_a_o), 65'(32'hFFFFFFFF));
      cyc();
    end
    ex_advance_i = 1'b1;
    cyc();
    clear_inputs();
    smp();
    check("done_release_state", 65'(state_o), 65'(0));
    check("done_release_ready", 65'(mult_ready_o), 65'(0));
    cyc();

    // Asynchronous reset between edges in MUL_BUSY, then a fresh multiply.
    mult_start_i = 1'b1; signed_mult_i = 1'b0; mult_opdata1_i = 32'd9; mult_opdata2_i = 32'd9;
    cyc();
    #2;
    rst = 1'b0;
    mult_start_i = 1'b0;
    #1;
    chk_zero("async_reset_outputs");
    smp();
    rst = 1'b1;
    cyc();
    issue_mult(1'b0, 32'd6, 32'd7, 64'd42);

    repeat (3) cyc();
    check("scoreboard_drain", 65'(exp_q.size()), 65'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
